// File: rtl/store_queue_drain.sv
// Circular store queue: dispatch allocates in order, address RS and CDB fill entries,
// ROB commit marks them, and committed entries drain one at a time to the dcache write port.
package sq_pkg;
  typedef enum logic [2:0] {ST_SB = 3'b000, ST_SH = 3'b001, ST_SW = 3'b010} store_f3_t;
endpackage

module store_queue_drain
  import sq_pkg::*;
#(
  parameter int SQ_DEPTH              = 8,
  parameter int STORE_QUEUE_PTR_WIDTH = 3,
  parameter int PHYSICAL_REG_WIDTH    = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sq_alloc,
  input  logic [PHYSICAL_REG_WIDTH-1:0]    alloc_data_tag,
  input  logic                             alloc_data_valid,
  input  logic [31:0]                      alloc_data,
  output logic [STORE_QUEUE_PTR_WIDTH-1:0] sq_alloc_idx,
  output logic                             sq_full,
  input  logic                             store_address_ready,
  input  logic [STORE_QUEUE_PTR_WIDTH-1:0] SQ_entry_idx,
  input  logic [31:0]                      addr_v_in,
  input  logic [3:0]                       wmask_in,
  input  store_f3_t                        store_type,
  input  logic                             cdb_valid,
  input  logic [PHYSICAL_REG_WIDTH-1:0]    cdb_tag,
  input  logic [31:0]                      cdb_data,
  input  logic                             rob_commit_store,
  input  logic                             flush,
  output logic                             dmem_write,
  output logic [31:0]                      dmem_addr,
  output logic [3:0]                       dmem_wmask,
  output logic [31:0]                      dmem_wdata,
  input  logic                             dmem_resp,
  output logic                             sq_empty
);
  localparam int PW = STORE_QUEUE_PTR_WIDTH;
  typedef logic [PW:0] ptr_t;

  typedef struct packed {
    logic                          valid;
    logic                          addr_valid;
    logic                          data_valid;
    logic                          committed;
    logic [PHYSICAL_REG_WIDTH-1:0] tag;
    logic [29:0]                   waddr;
    logic [3:0]                    wmask;
    store_f3_t                     st;
    logic [31:0]                   data;
  } sq_entry_t;

  typedef enum logic {IDLE, WRITE} state_t;

  sq_entry_t q    [SQ_DEPTH];
  sq_entry_t q_nx [SQ_DEPTH];
  ptr_t      head, cmt, tail, cmt_nx;
  state_t    state, state_nx;
  logic      do_alloc, do_commit, pop, head_ok, load, alloc_hit;
  logic      unused_addr_lsb;

  assign unused_addr_lsb = ^addr_v_in[1:0];

  assign sq_empty     = (head == tail);
  assign sq_full      = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
  assign sq_alloc_idx = tail[PW-1:0];
  assign do_alloc     = sq_alloc && !sq_full && !flush;
  assign do_commit    = rob_commit_store && (cmt != tail);
  assign cmt_nx       = cmt + ptr_t'(do_commit);
  assign pop          = (state == WRITE) && dmem_resp;
  assign alloc_hit    = cdb_valid && (cdb_tag == alloc_data_tag);
  assign head_ok      = q[head[PW-1:0]].valid && q[head[PW-1:0]].committed &&
                        q[head[PW-1:0]].addr_valid && q[head[PW-1:0]].data_valid;
  assign dmem_write   = (state == WRITE);

  function automatic logic [31:0] lanes(store_f3_t t, logic [31:0] d);
    case (t)
      ST_SB:   return {4{d[7:0]}};
      ST_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      q_nx[i] = q[i];
      if (store_address_ready && q[i].valid && SQ_entry_idx == PW'(i)) begin
        q_nx[i].waddr      = addr_v_in[31:2];
        q_nx[i].wmask      = wmask_in;
        q_nx[i].st         = store_type;
        q_nx[i].addr_valid = 1'b1;
      end
      if (cdb_valid && q[i].valid && !q[i].data_valid && q[i].tag == cdb_tag) begin
        q_nx[i].data       = cdb_data;
        q_nx[i].data_valid = 1'b1;
      end
      if (do_commit && cmt[PW-1:0] == PW'(i))
        q_nx[i].committed = 1'b1;
      if (pop && head[PW-1:0] == PW'(i))
        q_nx[i].valid = 1'b0;
      // Squash the uncommitted window [new commit, tail) by distance from the commit pointer.
      if (flush && ({1'b0, PW'(i) - cmt_nx[PW-1:0]} < (tail - cmt_nx)))
        q_nx[i].valid = 1'b0;
      if (do_alloc && tail[PW-1:0] == PW'(i)) begin
        q_nx[i].valid      = 1'b1;
        q_nx[i].addr_valid = 1'b0;
        q_nx[i].committed  = 1'b0;
        q_nx[i].tag        = alloc_data_tag;
        q_nx[i].data_valid = alloc_data_valid || alloc_hit;
        q_nx[i].data       = alloc_data_valid ? alloc_data : cdb_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SQ_DEPTH; i++) q[i] <= '0;
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) q[i] <= q_nx[i];
      if (pop) head <= head + ptr_t'(1);
      cmt  <= cmt_nx;
      tail <= flush ? cmt_nx : tail + ptr_t'(do_alloc);
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE:  if (head_ok) begin
               state_nx = WRITE;
               load     = 1'b1;
             end
      WRITE: if (dmem_resp) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem_addr  <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        dmem_addr  <= {q[head[PW-1:0]].waddr, 2'b00};
        dmem_wmask <= q[head[PW-1:0]].wmask;
        dmem_wdata <= lanes(q[head[PW-1:0]].st, q[head[PW-1:0]].data);
      end
    end
  end

  a_commit_has_entry: assert property (@(posedge clk) disable iff (rst)
    rob_commit_store |-> (cmt != tail));

endmodule

// File: tb/tb_store_queue_drain.sv
// Directed bench for store_queue_drain: alloc/addr/CDB/commit/drain, full, flush, wrap, reset mid-write.
module tb_store_queue_drain;
  import sq_pkg::*;

  logic        clk = 0, rst = 1;
  logic        sq_alloc = 0, alloc_data_valid = 0;
  logic [5:0]  alloc_data_tag = 0, cdb_tag = 0;
  logic [31:0] alloc_data = 0, addr_v_in = 0, cdb_data = 0;
  logic [2:0]  sq_alloc_idx, SQ_entry_idx = 0;
  logic        sq_full, sq_empty, store_address_ready = 0, cdb_valid = 0;
  logic [3:0]  wmask_in = 0, dmem_wmask;
  store_f3_t   store_type = ST_SW;
  logic        rob_commit_store = 0, flush = 0, dmem_write, dmem_resp = 0;
  logic [31:0] dmem_addr, dmem_wdata;
  int          checks = 0, errors = 0;
  int          exp_idx;

  store_queue_drain dut (
    .clk(clk), .rst(rst), .sq_alloc(sq_alloc), .alloc_data_tag(alloc_data_tag),
    .alloc_data_valid(alloc_data_valid), .alloc_data(alloc_data), .sq_alloc_idx(sq_alloc_idx),
    .sq_full(sq_full), .store_address_ready(store_address_ready), .SQ_entry_idx(SQ_entry_idx),
    .addr_v_in(addr_v_in), .wmask_in(wmask_in), .store_type(store_type), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rob_commit_store(rob_commit_store), .flush(flush),
    .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .sq_empty(sq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic alloc(input logic [5:0] tag, input logic dv, input logic [31:0] d);
    sq_alloc = 1; alloc_data_tag = tag; alloc_data_valid = dv; alloc_data = d;
    tick();
    sq_alloc = 0; alloc_data_valid = 0;
  endtask

  task automatic set_addr(input logic [2:0] idx, input logic [31:0] a, input logic [3:0] m,
                          input store_f3_t t);
    store_address_ready = 1; SQ_entry_idx = idx; addr_v_in = a; wmask_in = m; store_type = t;
  endtask

  task automatic idle_in();
    store_address_ready = 0; cdb_valid = 0; rob_commit_store = 0; flush = 0; sq_alloc = 0;
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    while (!dmem_write && n < 20) begin tick(); n++; end
    chk(tag, {31'b0, dmem_write}, 32'd1);
  endtask

  task automatic resp();
    dmem_resp = 1; tick(); dmem_resp = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    // reset state
    chk("rst_write", {31'b0, dmem_write}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wmask", {28'b0, dmem_wmask}, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_full", {31'b0, sq_full}, 0);
    chk("rst_empty", {31'b0, sq_empty}, 1);
    chk("rst_idx", {29'b0, sq_alloc_idx}, 0);

    // three allocs with data pending
    alloc(5, 0, 0);  chk("alloc_idx1", {29'b0, sq_alloc_idx}, 1);
    alloc(6, 0, 0);  chk("alloc_idx2", {29'b0, sq_alloc_idx}, 2);
    alloc(7, 0, 0);  chk("alloc_idx3", {29'b0, sq_alloc_idx}, 3);
    chk("alloc_empty", {31'b0, sq_empty}, 0);
    chk("alloc_nowrite", {31'b0, dmem_write}, 0);

    // entry 0: sb at 0x1003, data via CDB, then commit
    set_addr(0, 32'h1003, 4'b1000, ST_SB); tick(); idle_in();
    cdb_valid = 1; cdb_tag = 5; cdb_data = 32'hAB; tick(); idle_in();
    rob_commit_store = 1; tick(); idle_in();
    chk("sb_not_yet", {31'b0, dmem_write}, 0);
    tick();
    chk("sb_write", {31'b0, dmem_write}, 1);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_wmask", {28'b0, dmem_wmask}, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    tick(); tick();
    chk("sb_hold_write", {31'b0, dmem_write}, 1);
    chk("sb_hold_wdata", dmem_wdata, 32'hABABABAB);
    resp();
    chk("sb_drop", {31'b0, dmem_write}, 0);

    // entry 1: address, CDB and commit all in one cycle, sh lanes
    set_addr(1, 32'h2006, 4'b1100, ST_SH);
    cdb_valid = 1; cdb_tag = 6; cdb_data = 32'h1234CDEF; rob_commit_store = 1;
    tick(); idle_in();
    chk("sh_not_yet", {31'b0, dmem_write}, 0);
    tick();
    chk("sh_write", {31'b0, dmem_write}, 1);
    chk("sh_addr", dmem_addr, 32'h2004);
    chk("sh_wdata", dmem_wdata, 32'hCDEFCDEF);
    resp();

    // entry 2: sw
    set_addr(2, 32'h3000, 4'b1111, ST_SW);
    cdb_valid = 1; cdb_tag = 7; cdb_data = 32'hDEADBEEF; rob_commit_store = 1;
    tick(); idle_in();
    wait_write("sw_write");
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    resp();
    chk("drained_empty", {31'b0, sq_empty}, 1);

    // fill all 8 entries starting at idx 3
    for (int i = 0; i < 8; i++) alloc(6'(20 + i), 1, 32'h100 + i);
    chk("full_set", {31'b0, sq_full}, 1);
    chk("full_idx", {29'b0, sq_alloc_idx}, 3);
    alloc(40, 1, 32'hBAD);
    chk("full_drop_idx", {29'b0, sq_alloc_idx}, 3);
    chk("full_drop_full", {31'b0, sq_full}, 1);
    set_addr(3, 32'h4000, 4'b1111, ST_SW); rob_commit_store = 1; tick(); idle_in();
    wait_write("full_write");
    chk("full_wdata", dmem_wdata, 32'h100);
    chk("full_during_write", {31'b0, sq_full}, 1);
    resp();
    chk("full_clear", {31'b0, sq_full}, 0);
    flush = 1; tick(); idle_in();
    chk("flush_all_empty", {31'b0, sq_empty}, 1);
    chk("flush_all_idx", {29'b0, sq_alloc_idx}, 4);

    // commit two, alloc three more, flush the uncommitted three
    alloc(1, 1, 32'hA5A5A5A5);
    alloc(2, 1, 32'h5A5A5A5A);
    rob_commit_store = 1; tick(); tick(); idle_in();
    alloc(3, 1, 32'h3); alloc(4, 1, 32'h4); alloc(8, 1, 32'h8);
    chk("pre_flush_idx", {29'b0, sq_alloc_idx}, 1);
    flush = 1; sq_alloc = 1; tick(); idle_in();
    chk("flush_idx", {29'b0, sq_alloc_idx}, 6);
    chk("flush_not_empty", {31'b0, sq_empty}, 0);
    set_addr(4, 32'h5000, 4'b1111, ST_SW); tick();
    set_addr(5, 32'h5004, 4'b1111, ST_SW); tick(); idle_in();
    wait_write("flushA_write");
    chk("flushA_addr", dmem_addr, 32'h5000);
    chk("flushA_wdata", dmem_wdata, 32'hA5A5A5A5);
    resp();
    chk("gap_low", {31'b0, dmem_write}, 0);
    tick();
    chk("flushB_write", {31'b0, dmem_write}, 1);
    chk("flushB_addr", dmem_addr, 32'h5004);
    chk("flushB_wdata", dmem_wdata, 32'h5A5A5A5A);
    resp();
    chk("reuse_idx", {29'b0, sq_alloc_idx}, 6);
    alloc(9, 1, 32'h9);
    chk("reuse_next", {29'b0, sq_alloc_idx}, 7);
    tick(); tick();
    chk("uncommitted_nowrite", {31'b0, dmem_write}, 0);
    flush = 1; tick(); idle_in();
    chk("flush2_empty", {31'b0, sq_empty}, 1);

    // wrap: 20 single-entry round trips from idx 6
    exp_idx = 6;
    for (int i = 0; i < 20; i++) begin
      chk("wrap_idx", {29'b0, sq_alloc_idx}, 32'(exp_idx));
      if (i % 2 == 1) begin
        cdb_valid = 1; cdb_tag = 30; cdb_data = 32'hC0DE0000 + i;
        alloc(30, 0, 32'hFFFFFFFF);
      end else begin
        alloc(31, 1, 32'h1000 + i);
      end
      idle_in();
      set_addr(3'(exp_idx), 32'h6000 + 4 * i, 4'b1111, ST_SW); rob_commit_store = 1;
      tick(); idle_in();
      wait_write("wrap_write");
      chk("wrap_addr", dmem_addr, 32'h6000 + 4 * i);
      chk("wrap_wdata", dmem_wdata, (i % 2 == 1) ? 32'hC0DE0000 + i : 32'h1000 + i);
      resp();
      chk("wrap_empty", {31'b0, sq_empty}, 1);
      chk("wrap_full", {31'b0, sq_full}, 0);
      exp_idx = (exp_idx + 1) % 8;
    end

    // reset while a write is outstanding
    alloc(11, 1, 32'h77);
    set_addr(3'(exp_idx), 32'h7000, 4'b1111, ST_SW); rob_commit_store = 1; tick(); idle_in();
    wait_write("rstw_write");
    #3 rst = 1;
    #1;
    chk("rstw_write_low", {31'b0, dmem_write}, 0);
    chk("rstw_empty", {31'b0, sq_empty}, 1);
    chk("rstw_idx", {29'b0, sq_alloc_idx}, 0);
    chk("rstw_addr", dmem_addr, 0);
    tick();
    rst = 0;
    resp();
    chk("late_resp_write", {31'b0, dmem_write}, 0);
    chk("late_resp_empty", {31'b0, sq_empty}, 1);
    alloc(12, 1, 32'h1);
    chk("post_rst_idx", {29'b0, sq_alloc_idx}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
